// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and queued load results
// onto one register-file write port, with anti-starvation for loads and
// pending-write hazard lookups for the decode stage.
module wb_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic [2:0]  lsu_funct3,
    input  logic [1:0]  lsu_byte_off,
    output logic        reg_write,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_hit1,
    output logic        chk_hit2
);

    // Two-slot circular load queue; head points at the oldest entry.
    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        head;
    logic [1:0]  count;
    logic [1:0]  starve_cnt;

    logic        fifo_empty;
    logic        fifo_full;
    logic        tail;
    logic        force_load;
    logic        alu_accept;
    logic        enq;
    logic        deq;
    logic        slot0_valid;
    logic        slot1_valid;

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] ext_data;

    logic        sel_valid;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // Queue status, handshakes and the per-cycle arbitration decision.
    always_comb begin
        fifo_empty  = (count == 2'd0);
        fifo_full   = (count == 2'd2);
        tail        = head ^ count[0];
        force_load  = !fifo_empty && (starve_cnt == 2'd3);
        alu_ready   = !force_load;
        lsu_ready   = !fifo_full;
        alu_accept  = alu_valid && alu_ready;
        enq         = lsu_valid && lsu_ready;
        deq         = !fifo_empty && (force_load || !alu_valid);
        slot0_valid = fifo_full || (count == 2'd1 && head == 1'b0);
        slot1_valid = fifo_full || (count == 2'd1 && head == 1'b1);
    end

    // Align and extend the incoming load word before it is queued.
    always_comb begin
        byte_val = lsu_data[{lsu_byte_off, 3'b000} +: 8];
        half_val = lsu_byte_off[1] ? lsu_data[31:16] : lsu_data[15:0];
        case (lsu_funct3)
            3'b000:  ext_data = {{24{byte_val[7]}}, byte_val};
            3'b001:  ext_data = {{16{half_val[15]}}, half_val};
            3'b100:  ext_data = {24'd0, byte_val};
            3'b101:  ext_data = {16'd0, half_val};
            default: ext_data = lsu_data;
        endcase
    end

    // Pick the result that owns the write port this cycle.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = 32'd0;
        if (deq) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[head];
            sel_data  = fifo_data[head];
        end else if (alu_accept) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end
    end

    // Queue pointers and the starvation counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= 1'b0;
            count      <= 2'd0;
            starve_cnt <= 2'd0;
        end else begin
            head  <= head ^ deq;
            count <= count + {1'b0, enq} - {1'b0, deq};
            if (deq || fifo_empty) begin
                starve_cnt <= 2'd0;
            end else if (alu_accept) begin
                starve_cnt <= starve_cnt + 2'd1;
            end
        end
    end

    // Queue payload storage; validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[tail]   <= lsu_rd;
            fifo_data[tail] <= ext_data;
        end
    end

    // Registered write port; writes to x0 are consumed but never asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write <= 1'b0;
            waddr     <= 5'd0;
            wdata     <= 32'd0;
        end else begin
            reg_write <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                waddr <= sel_rd;
                wdata <= sel_data;
            end
        end
    end

    // Hazard lookup against queued loads and the write in flight.
    always_comb begin
        chk_hit1 = (chk_addr1 != 5'd0) &&
                   ((slot0_valid && fifo_rd[0] == chk_addr1) ||
                    (slot1_valid && fifo_rd[1] == chk_addr1) ||
                    (reg_write && waddr == chk_addr1));
        chk_hit2 = (chk_addr2 != 5'd0) &&
                   ((slot0_valid && fifo_rd[0] == chk_addr2) ||
                    (slot1_valid && fifo_rd[1] == chk_addr2) ||
                    (reg_write && waddr == chk_addr2));
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first:
  clk  in  1  clock, all state updates on rising edge
  reset_n  in  1  reset, asynchronous, active-low
  alu_valid  in  1  ALU result present this cycle
  alu_ready  out  1  ALU result accepted this cycle
  alu_rd  in  5  ALU destination register
  alu_data  in  32  ALU result
  lsu_valid  in  1  load result present
  lsu_ready  out  1  load queue can accept
  lsu_rd  in  5  load destination register
  lsu_data  in  32  raw aligned memory word
  lsu_funct3  in  3  load type (RV32I encoding)
  lsu_byte_off  in  2  byte offset of load address
  reg_write  out  1  register-file write enable
  waddr  out  5  register-file write index
  wdata  out  32  register-file write data
  chk_addr1, chk_addr2  in  5 each  decode-stage source indices
  chk_hit1, chk_hit2  out  1 each  pending write to that index
REQ-002 SHALL use clk as the only clock and reset_n as its reset, asynchronous, active-low.

Function
REQ-003 SHALL hold load results in a 2-entry FIFO (rd, extended data); lsu_ready = FIFO not full, from registered state only.
REQ-004 SHALL enqueue when lsu_valid && lsu_ready; when full, no enqueue, even if a dequeue occurs the same cycle.
REQ-005 SHALL extend at enqueue: s = lsu_data >> (8*lsu_byte_off) for bytes; halfwords use lsu_byte_off[1] only (shift 0 or 16), ignoring bit 0.
REQ-006 SHALL produce: 000 LB sign-extend s[7:0]; 001 LH sign-extend s[15:0]; 100 LBU zero-extend s[7:0]; 101 LHU zero-extend s[15:0]; 010 and all other codes: lsu_data unmodified.
REQ-007 SHALL keep 2-bit starve_cnt: +1 each cycle the FIFO is non-empty and an ALU result is accepted; cleared when a FIFO entry is dequeued or the FIFO is empty.
REQ-008 SHALL arbitrate per cycle: if FIFO non-empty and starve_cnt==3, dequeue FIFO head and alu_ready=0; else if alu_valid, accept ALU (alu_ready=1); else if FIFO non-empty, dequeue head.
REQ-009 SHALL drive alu_ready combinationally = !(FIFO non-empty && starve_cnt==3); alu_ready may be 1 when alu_valid=0.
REQ-010 SHALL register the selected write: reg_write, waddr, wdata valid the cycle after selection (latency 1); reg_write=0 when nothing selected.
REQ-011 SHALL consume results with rd==0 normally but drive reg_write=0 for them; waddr/wdata then unspecified.
REQ-012 SHALL assert chk_hitN combinationally when chk_addrN!=0 and matches rd of any valid FIFO entry, or waddr while reg_write=1.
REQ-013 SHALL never write two results in one cycle; ALU results not accepted are held upstream (no drop).
REQ-014 SHALL preserve FIFO order of load results.

Reset
REQ-015 SHALL on reset_n low immediately clear: FIFO empty, starve_cnt=0, reg_write=0, waddr=0, wdata=0; thus lsu_ready=1, alu_ready=1, chk_hit1/2=0.
REQ-016 SHALL discard queued and staged results on reset mid-operation; none written after release.

Verification
REQ-017 ALU only: alu_valid=1, rd=5, data=0x1234 -> next cycle reg_write=1, waddr=5, wdata=0x1234.
REQ-018 LB: lsu_data=0x80FF0000, off=3, funct3=000, rd=7, ALU idle -> wdata=0xFFFFFF80, waddr=7, two cycles after lsu_valid; LHU off=2 same data -> 0x000080FF.
REQ-019 Starvation: alu_valid held 1, one load queued -> ALU wins 3 cycles, 4th cycle alu_ready=0 and load written next cycle, then ALU resumes.
REQ-020 Full: 2 loads queued with continuous ALU traffic -> lsu_ready=0; third lsu_valid not accepted until an entry dequeues; order preserved.
REQ-021 x0 and hazard: ALU rd=0 -> reg_write stays 0; load rd=9 queued, chk_addr1=9 -> chk_hit1=1 until the write cycle ends; chk_addr2=0 -> chk_hit2=0.
REQ-022 Reset with 2 queued loads -> outputs per REQ-015 asynchronously; no reg_write after release.
